axis_fir_unpack: RTL and testbench
==================================

AXIS_FIR_UNPACK -- requirements
Module: axis_fir_unpack

Interface
REQ-001 SHALL have parameter N, default 8: complex samples per beat.
REQ-002 SHALL have parameter SHIFT, default 1, legal range 0..2: right-shift applied before rounding.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port s_axis_tvalid, input, 1 bit: input beat valid.
REQ-006 SHALL have port s_axis_tready, output, 1 bit: input beat accepted when high with tvalid.
REQ-007 SHALL have port s_axis_tdata, input, 48*N bits: sample k real = [48k +: 18], imag = [48k+24 +: 18], two's complement; remaining bits ignored.
REQ-008 SHALL have port m_axis_tvalid, output, 1 bit: output beat valid.
REQ-009 SHALL have port m_axis_tready, input, 1 bit: downstream accept.
REQ-010 SHALL have port m_axis_tdata, output, 32*N bits: sample k real = [32k +: 16], imag = [32k+16 +: 16].
REQ-011 SHALL have port sat_flag, output, 1 bit: sticky, set by any saturation.
REQ-012 SHALL have port sat_clr, input, 1 bit: clears sat_flag and sat_cnt.
REQ-013 SHALL have port sat_cnt, output, 32 bits: saturation event count.

Function
REQ-014 SHALL process all 2N components independently and identically per beat.
REQ-015 SHALL compute y = (x + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up) for SHIFT>0, and y = x for SHIFT=0, with one guard bit so the rounding add never wraps.
REQ-016 SHALL saturate y to [-32768, 32767]; each component clamped is one saturation event.
REQ-017 SHALL be a 2-stage pipeline: stage 1 registers the rounded value, stage 2 registers the saturated value and drives m_axis_tdata.
REQ-018 SHALL use a global advance enable en = !m_axis_tvalid || m_axis_tready, and SHALL drive s_axis_tready = en.
REQ-019 SHALL carry a valid bit per stage; an accepted input beat appears on m_axis_tvalid exactly 2 cycles later if no stall occurs.
REQ-020 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 SHALL sustain one beat per cycle with no bubbles while m_axis_tready=1.
REQ-022 SHALL count a beat's saturation events when that beat enters stage 2.
REQ-023 SHALL take sat_clr over any same-cycle events: the cleared value is 0 and that cycle's events are discarded.
REQ-024 SHALL hold sat_cnt at 0xFFFFFFFF once it reaches that value, without wrapping.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear both stage valid bits, m_axis_tvalid, sat_flag and sat_cnt; m_axis_tdata SHALL reset to 0.
REQ-026 SHALL discard in-flight beats when reset is asserted mid-stream; s_axis_tready SHALL be 1 during and after reset.

Configuration
REQ-027 SHALL implement the 32-bit counter when macro AXIS_FIR_UNPACK_SAT_CNT_EN is defined.
REQ-028 SHALL, without that macro, tie sat_cnt to 0 and implement no counter logic; sat_flag is unaffected.

Verification
REQ-029 SHALL cover, with SHIFT=1 and all components driven with the same value: x=3 -> 2; x=-3 -> -1; x=65535 -> 32767 plus sat_flag; x=-70000 -> -32768 plus sat_flag.
REQ-030 SHALL cover this stream: 100 consecutive beats with m_axis_tready=1 -> 100 output beats, first one 2 cycles after the first accept, none lost or duplicated.
REQ-031 SHALL cover this stall: hold m_axis_tready=0 for 5 cycles mid-stream -> s_axis_tready=0 throughout, held output data unchanged, ordering preserved afterwards.
REQ-032 SHALL cover these counter cases with the macro defined: one beat with 16 components at 65535 -> sat_cnt=16; sat_clr in the same cycle as a saturating beat -> sat_cnt=0.
REQ-033 SHALL cover reset: assert rst for 1 cycle while 2 beats are in flight -> no output beat, m_axis_tvalid=0 on the next cycle, sat_cnt=0.
REQ-034 SHALL cover the build without the macro: saturating stimulus -> sat_cnt stays 0 and sat_flag=1.

Source files
------------

// File: rtl/axis_fir_unpack.sv
// axis_fir_unpack
// Converts beats of N complex samples carried as 18-bit two's-complement
// components in 24-bit lanes into 16-bit components. Each component is
// rounded (arithmetic right shift by SHIFT, round half up) and then
// saturated to the int16 range. Two-stage pipeline with a single global
// advance enable, so it runs one beat per clock and stalls as a whole.
//
// Optional build macro: AXIS_FIR_UNPACK_SAT_CNT_EN adds the 32-bit
// saturation event counter; without it sat_cnt is tied to zero.
//
// Ports
//   aclk, rst       clock, synchronous active-high reset
//   s_axis_*        input stream, tdata is 48*N bits (re/im at 48k, 48k+24)
//   m_axis_*        output stream, tdata is 32*N bits (re/im at 32k, 32k+16)
//   sat_flag        sticky, set when any component is clamped
//   sat_clr         clears sat_flag and sat_cnt, wins over same-cycle events
//   sat_cnt         saturating count of clamped components

module axis_fir_unpack #(
    parameter int unsigned N     = 8,
    parameter int unsigned SHIFT = 1
) (
    input  logic            aclk,
    input  logic            rst,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic [48*N-1:0] s_axis_tdata,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [32*N-1:0] m_axis_tdata,
    output logic            sat_flag,
    input  logic            sat_clr,
    output logic [31:0]     sat_cnt
);

    localparam int unsigned NC     = 2 * N;
    localparam int unsigned RndInt = (2 ** SHIFT) / 2;
    // One guard bit over the 18-bit input keeps the rounding add from wrapping.
    localparam logic signed [18:0] RndK   = 19'(RndInt);
    localparam logic signed [18:0] SatMax = 19'sd32767;
    localparam logic signed [18:0] SatMin = -19'sd32768;

    logic                    en;
    logic                    s1_valid_q;
    logic signed [18:0]      rnd  [NC];
    logic signed [18:0]      s1_q [NC];
    logic [NC-1:0]           clamp;
    logic [32*N-1:0]         sat_data;
    logic                    m_valid_q;
    logic [32*N-1:0]         m_data_q;
    logic                    sat_flag_q;
    logic                    ev_valid;
    logic                    unused_tdata;

    // Reset forces the enable high so the input side reads ready during reset.
    assign en            = rst || !m_valid_q || m_axis_tready;
    assign s_axis_tready = en;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign sat_flag      = sat_flag_q;

    // Upper six bits of every 24-bit lane carry nothing.
    assign unused_tdata = ^s_axis_tdata;

    // A beat's saturation events are counted as it moves into stage 2.
    assign ev_valid = s1_valid_q && en;

    // Stage 1 input: sign-extend by one bit, add half an LSB, shift.
    always_comb begin
        for (int c = 0; c < NC; c++) begin
            rnd[c] = ($signed({s_axis_tdata[24*c+17], s_axis_tdata[24*c +: 18]}) + RndK)
                     >>> SHIFT;
        end
    end

    // Stage 2 input: clamp each rounded component to int16.
    always_comb begin
        clamp    = '0;
        sat_data = '0;
        for (int c = 0; c < NC; c++) begin
            if (s1_q[c] > SatMax) begin
                sat_data[16*c +: 16] = 16'h7fff;
                clamp[c]             = 1'b1;
            end else if (s1_q[c] < SatMin) begin
                sat_data[16*c +: 16] = 16'h8000;
                clamp[c]             = 1'b1;
            end else begin
                sat_data[16*c +: 16] = s1_q[c][15:0];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            for (int c = 0; c < NC; c++) begin
                s1_q[c] <= '0;
            end
        end else if (en) begin
            s1_valid_q <= s_axis_tvalid;
            m_valid_q  <= s1_valid_q;
            m_data_q   <= sat_data;
            for (int c = 0; c < NC; c++) begin
                s1_q[c] <= rnd[c];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
        end else if (sat_clr) begin
            sat_flag_q <= 1'b0;
        end else if (ev_valid && (|clamp)) begin
            sat_flag_q <= 1'b1;
        end
    end

`ifdef AXIS_FIR_UNPACK_SAT_CNT_EN
    localparam int unsigned EvW = $clog2(NC + 1);

    logic [EvW-1:0] ev_cnt;
    logic [32:0]    cnt_sum;
    logic [31:0]    sat_cnt_q;

    always_comb begin
        ev_cnt = '0;
        if (ev_valid) begin
            for (int c = 0; c < NC; c++) begin
                ev_cnt = ev_cnt + EvW'(clamp[c]);
            end
        end
        cnt_sum = {1'b0, sat_cnt_q} + 33'(ev_cnt);
    end

    // Carry out of the 32-bit sum means the count pins at all-ones.
    always_ff @(posedge aclk) begin
        if (rst || sat_clr) begin
            sat_cnt_q <= '0;
        end else if (cnt_sum[32]) begin
            sat_cnt_q <= '1;
        end else begin
            sat_cnt_q <= cnt_sum[31:0];
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_fir_unpack.sv
// Bench for axis_fir_unpack (N=8, SHIFT=1): vector table of splatted
// component values, streaming, stall, counter and reset sequences, with a
// scoreboard fed on input acceptance and drained on output transfer.

module tb_axis_fir_unpack;

    localparam int unsigned N     = 8;
    localparam int unsigned SHIFT = 1;
    localparam int unsigned NC    = 2 * N;
`ifdef AXIS_FIR_UNPACK_SAT_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic           aclk = 1'b0;
    logic           rst;
    logic           s_valid;
    logic           s_ready;
    logic [383:0]   s_data;
    logic           m_valid;
    logic           m_ready;
    logic [255:0]   m_data;
    logic           sat_flag;
    logic           sat_clr;
    logic [31:0]    sat_cnt;

    axis_fir_unpack #(
        .N     (N),
        .SHIFT (SHIFT)
    ) dut (
        .aclk          (aclk),
        .rst           (rst),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tdata  (s_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_data),
        .sat_flag      (sat_flag),
        .sat_clr       (sat_clr),
        .sat_cnt       (sat_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [17:0] x;
        logic [15:0] y;
        logic        sat;
    } vec_t;

    vec_t         vt [13];
    logic [255:0] sb [$];
    logic [255:0] last_out;
    logic [255:0] mon_exp;
    int n_vec = 0;
    int n_bad = 0;
    int n_out = 0;
    int n_in  = 0;
    int cyc   = 0;
    int first_acc_cyc = -1;
    int last_acc_cyc  = -1;
    int first_out_cyc = -1;

    always @(posedge aclk) cyc++;

    task automatic check_w(input string name, input logic [255:0] act, input logic [255:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic req);
        check_w(name, 256'(act), 256'(req));
    endtask

    // Independent reference: floor((x + 2^(S-1)) / 2^S), then clamp to int16.
    function automatic logic [255:0] model(input logic [383:0] d);
        logic [255:0] o;
        logic [31:0]  qv;
        int x, t, q, dv;
        dv = 2 ** SHIFT;
        o  = '0;
        for (int c = 0; c < NC; c++) begin
            x = int'($signed(d[24*c +: 18]));
            t = x + dv / 2;
            q = t / dv;
            if (t < 0 && q * dv != t) q = q - 1;
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
            qv = q;
            o[16*c +: 16] = qv[15:0];
        end
        return o;
    endfunction

    function automatic logic [383:0] splat(input logic [17:0] x);
        logic [383:0] d;
        for (int c = 0; c < NC; c++) begin
            d[24*c +: 18]    = x;
            d[24*c+18 +: 6]  = 6'b101010;
        end
        return d;
    endfunction

    function automatic logic [255:0] splat_out(input logic [15:0] y);
        logic [255:0] o;
        for (int c = 0; c < NC; c++) o[16*c +: 16] = y;
        return o;
    endfunction

    function automatic logic [383:0] rand_beat();
        logic [383:0] d;
        for (int w = 0; w < 12; w++) d[32*w +: 32] = $urandom();
        return d;
    endfunction

    // Monitor: pop before push so a beat can never be compared against itself.
    always @(negedge aclk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (m_valid && m_ready) begin
                n_out++;
                last_out = m_data;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                check_b("output beat expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    check_w("scoreboard data", m_data, mon_exp);
                end
            end
            if (s_valid && s_ready) begin
                sb.push_back(model(s_data));
                n_in++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [383:0] d);
        bit rdy;
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            rdy = s_ready;
            @(posedge aclk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        check_b("input accepted", ok, 1'b1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check_b("pipeline drained", ok, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        logic [255:0] held;
        bit ok;

        vt[0]  = '{18'd3,       16'h0002, 1'b0};
        vt[1]  = '{-18'sd3,     16'hffff, 1'b0};
        vt[2]  = '{18'd65535,   16'h7fff, 1'b1};
        vt[3]  = '{-18'sd70000, 16'h8000, 1'b1};
        vt[4]  = '{18'd0,       16'h0000, 1'b0};
        vt[5]  = '{18'd1,       16'h0001, 1'b0};
        vt[6]  = '{-18'sd1,     16'h0000, 1'b0};
        vt[7]  = '{-18'sd2,     16'hffff, 1'b0};
        vt[8]  = '{18'd65534,   16'h7fff, 1'b0};
        vt[9]  = '{-18'sd65536, 16'h8000, 1'b0};
        vt[10] = '{-18'sd65538, 16'h8000, 1'b1};
        vt[11] = '{18'h1ffff,   16'h7fff, 1'b1};
        vt[12] = '{18'h20000,   16'h8000, 1'b1};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        sat_clr = 1'b0;
        @(negedge aclk);
        check_b("ready during reset", s_ready, 1'b1);
        step();
        step();
        rst = 1'b0;
        check_b("reset m_valid", m_valid, 1'b0);
        check_b("reset sat_flag", sat_flag, 1'b0);
        check_w("reset sat_cnt", 256'(sat_cnt), 256'(0));
        check_w("reset m_data", m_data, 256'(0));
        check_b("ready after reset", s_ready, 1'b1);

        // Single-beat vectors, all components equal.
        for (int i = 0; i < 13; i++) begin
            sat_clr = 1'b1;
            step();
            sat_clr = 1'b0;
            check_b($sformatf("vec%0d flag cleared", i), sat_flag, 1'b0);
            send(splat(vt[i].x));
            drain();
            check_w($sformatf("vec%0d data", i), last_out, splat_out(vt[i].y));
            check_b($sformatf("vec%0d sat_flag", i), sat_flag, vt[i].sat);
            check_w($sformatf("vec%0d sat_cnt", i), 256'(sat_cnt),
                    256'((CntEn && vt[i].sat) ? 16 : 0));
        end

        // Flag stays set across a clean beat.
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        send(splat(18'd65535));
        send(splat(18'd0));
        drain();
        check_b("sat_flag sticky", sat_flag, 1'b1);
        check_w("sticky last data", last_out, 256'(0));

        // 100 back-to-back beats.
        drain();
        step();
        step();
        first_acc_cyc = -1;
        first_out_cyc = -1;
        base = n_out;
        for (int b = 0; b < 100; b++) send(rand_beat());
        drain();
        check_w("stream beat count", 256'(n_out - base), 256'(100));
        check_w("stream latency", 256'(first_out_cyc - first_acc_cyc), 256'(2));
        check_w("stream no bubbles", 256'(last_acc_cyc - first_acc_cyc), 256'(99));

        // Five-cycle downstream stall mid-stream.
        step();
        base = n_out;
        fork
            begin
                for (int b = 0; b < 20; b++) send(rand_beat());
            end
            begin
                ok = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    if (n_out >= base + 5) begin
                        ok = 1'b1;
                        break;
                    end
                    step();
                end
                check_b("stall point reached", ok, 1'b1);
                m_ready = 1'b0;
                held    = m_data;
                check_b("stall m_valid", m_valid, 1'b1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge aclk);
                    check_b($sformatf("stall%0d s_ready", i), s_ready, 1'b0);
                    check_b($sformatf("stall%0d m_valid", i), m_valid, 1'b1);
                    check_w($sformatf("stall%0d held data", i), m_data, held);
                end
                @(posedge aclk);
                #1;
                m_ready = 1'b1;
            end
        join
        drain();
        check_w("stall beat count", 256'(n_out - base), 256'(20));

`ifdef AXIS_FIR_UNPACK_SAT_CNT_EN
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        send(splat(18'd65535));
        drain();
        check_w("cnt one beat", 256'(sat_cnt), 256'(16));
        send(splat(18'd65535));
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check_b("clr beat in stage 2", m_valid, 1'b1);
        check_w("cnt clr wins", 256'(sat_cnt), 256'(0));
        check_b("flag clr wins", sat_flag, 1'b0);
        drain();
        send(splat(-18'sd70000));
        send(splat(18'd65535));
        drain();
        check_w("cnt accumulates", 256'(sat_cnt), 256'(32));
`else
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        send(splat(18'd65535));
        drain();
        check_w("no-counter sat_cnt", 256'(sat_cnt), 256'(0));
        check_b("no-counter sat_flag", sat_flag, 1'b1);
`endif

        // Reset with two beats in flight and the output stalled.
        m_ready = 1'b0;
        send(splat(18'd65535));
        send(splat(-18'sd70000));
        check_b("two in flight", m_valid, 1'b1);
        rst = 1'b1;
        @(negedge aclk);
        check_b("ready in mid reset", s_ready, 1'b1);
        @(posedge aclk);
        #1;
        rst = 1'b0;
        check_b("post-reset m_valid", m_valid, 1'b0);
        check_w("post-reset sat_cnt", 256'(sat_cnt), 256'(0));
        check_b("post-reset sat_flag", sat_flag, 1'b0);
        check_w("post-reset m_data", m_data, 256'(0));
        base    = n_out;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_w("no beat after reset", 256'(n_out - base), 256'(0));
        check_b("idle after reset", m_valid, 1'b0);

        check_w("scoreboard empty", 256'(sb.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
